// File: rtl/fpu_arb_pkg.sv
// Shared types and default sizes for the FPU memory-port arbiter.
package fpu_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_e;
    typedef enum logic {ARB_RD, ARB_WR} arb_op_e;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_TIMEOUT = 256;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first eligible index after last_grant, wrapping.
module rr_priority_picker
    import fpu_arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);
    logic [IDX_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/fpu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among FPU requesters, one transaction per grant.
// Optional BUSY watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_mem_arbiter
    import fpu_arb_pkg::*;
#(
    parameter  int NUM_REQ        = ARB_NUM_REQ,
    parameter  int ADDR_W         = ARB_ADDR_W,
    parameter  int DATA_W         = ARB_DATA_W,
    parameter  int TIMEOUT_CYCLES = ARB_TIMEOUT,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic [NUM_REQ-1:0]              req_avail,
    input  logic [NUM_REQ-1:0]              req_r_en,
    input  logic [NUM_REQ-1:0]              req_w_en,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_ptr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [DATA_W-1:0]               req_rdata,
    output logic                            mem_avail,
    output logic                            mem_r_en,
    output logic                            mem_w_en,
    output logic [ADDR_W-1:0]               mem_ptr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic                            mem_done,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic                            busy,
    output logic [IDX_W-1:0]                grant_id,
    output logic                            timeout_err
);
    arb_state_e          state, state_nxt;
    logic [IDX_W-1:0]    last_grant;
    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [IDX_W-1:0]    winner;
    arb_op_e             win_op;
    logic                timeout_hit;

    assign eligible = req_avail & (req_r_en | req_w_en);
    assign win_op   = req_w_en[winner] ? ARB_WR : ARB_RD;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .eligible   (eligible),
        .last_grant (last_grant),
        .found      (found),
        .winner     (winner)
    );

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            to_cnt <= '0;
        else if (state == ARB_IDLE && found)
            to_cnt <= '0;
        else if (state == ARB_BUSY)
            to_cnt <= to_cnt + CNT_W'(1);
    end

    // A real completion arriving on the limit cycle wins over the watchdog.
    assign timeout_hit = (state == ARB_BUSY) && (to_cnt == CNT_W'(TIMEOUT_CYCLES)) && !mem_done;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:    if (found) state_nxt = ARB_BUSY;
            ARB_BUSY:    if (mem_done || timeout_hit) state_nxt = ARB_RELEASE;
            ARB_RELEASE: state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state       <= ARB_IDLE;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            grant_id    <= '0;
            busy        <= 1'b0;
            mem_avail   <= 1'b0;
            mem_r_en    <= 1'b0;
            mem_w_en    <= 1'b0;
            mem_ptr     <= '0;
            mem_wdata   <= '0;
            req_done    <= '0;
            req_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_done    <= '0;
            req_rdata   <= '0;
            timeout_err <= 1'b0;
            case (state)
                ARB_IDLE: if (found) begin
                    last_grant <= winner;
                    grant_id   <= winner;
                    busy       <= 1'b1;
                    mem_avail  <= 1'b1;
                    mem_r_en   <= (win_op == ARB_RD);
                    mem_w_en   <= (win_op == ARB_WR);
                    mem_ptr    <= req_ptr[winner];
                    mem_wdata  <= req_wdata[winner];
                end
                ARB_BUSY: if (mem_done || timeout_hit) begin
                    mem_avail          <= 1'b0;
                    mem_r_en           <= 1'b0;
                    mem_w_en           <= 1'b0;
                    req_done[grant_id] <= 1'b1;
                    req_rdata          <= mem_done ? mem_rdata : '0;
                    timeout_err        <= timeout_hit;
                end
                ARB_RELEASE: busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fpu_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef FPU_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst_l;
    logic [N-1:0]         req_avail, req_r_en, req_w_en;
    logic [N-1:0][AW-1:0] req_ptr;
    logic [N-1:0][DW-1:0] req_wdata;
    logic [N-1:0]         req_done;
    logic [DW-1:0]        req_rdata;
    logic                 mem_avail, mem_r_en, mem_w_en;
    logic [AW-1:0]        mem_ptr;
    logic [DW-1:0]        mem_wdata, mem_rdata;
    logic                 mem_done, busy, timeout_err;
    logic [IW-1:0]        grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_l(rst_l),
        .req_avail(req_avail), .req_r_en(req_r_en), .req_w_en(req_w_en),
        .req_ptr(req_ptr), .req_wdata(req_wdata),
        .req_done(req_done), .req_rdata(req_rdata),
        .mem_avail(mem_avail), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_ptr(mem_ptr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a grant occupies the port until mem_done,
    // then one cycle of done pulse, then one free cycle before the next pick.
    logic          m_in, m_wr;
    int            m_cur, m_last, m_start, m_free_at, m_cyc;
    logic [AW-1:0] m_ptr;
    logic [DW-1:0] m_wd;
    logic [N-1:0]  e_done;
    logic [DW-1:0] e_rdata;
    logic          e_to;

    function automatic int rr_pick(input logic [N-1:0] el, input int lg);
        for (int k = 1; k <= N; k++)
            if (el[(lg + k) % N]) return (lg + k) % N;
        return 0;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] el;
        if (!rst_l) begin
            m_in = 1'b0; m_wr = 1'b0; m_cur = 0; m_last = N - 1;
            m_start = 0; m_free_at = 0; m_cyc = 0;
            m_ptr = '0; m_wd = '0; e_done = '0; e_rdata = '0; e_to = 1'b0;
        end else begin
            chk("m_avail", mem_avail, m_in);
            chk("m_busy", busy, m_in || (e_done != '0));
            chk("m_r_en", mem_r_en, m_in && !m_wr);
            chk("m_w_en", mem_w_en, m_in && m_wr);
            chk("m_gid", grant_id, m_cur);
            chk("m_done", req_done, e_done);
            chk("m_to", timeout_err, e_to);
            if (m_in) begin
                chk("m_ptr", mem_ptr, m_ptr);
                chk("m_wdata", mem_wdata, m_wd);
            end
            if (e_done != '0) chk("m_rdata", req_rdata, e_rdata);

            el = req_avail & (req_r_en | req_w_en);
            e_done = '0; e_rdata = '0; e_to = 1'b0;
            if (m_in) begin
                if (mem_done) begin
                    m_in = 1'b0; e_done[m_cur] = 1'b1; e_rdata = mem_rdata; m_free_at = m_cyc + 2;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (m_cyc - m_start == TO) begin
                    m_in = 1'b0; e_done[m_cur] = 1'b1; e_to = 1'b1; m_free_at = m_cyc + 2;
                end
`endif
            end else if (m_cyc >= m_free_at && el != '0) begin
                m_cur = rr_pick(el, m_last); m_last = m_cur;
                m_in = 1'b1; m_start = m_cyc + 1;
                m_wr = req_w_en[m_cur]; m_ptr = req_ptr[m_cur]; m_wd = req_wdata[m_cur];
            end
            m_cyc++;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        req_avail = '0; req_r_en = '0; req_w_en = '0;
        req_ptr = '0; req_wdata = '0; mem_done = 1'b0; mem_rdata = '0;
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_done"}, req_done, 0);
        chk({p, "_rdata"}, req_rdata, 0);
        chk({p, "_avail"}, mem_avail, 0);
        chk({p, "_r_en"}, mem_r_en, 0);
        chk({p, "_w_en"}, mem_w_en, 0);
        chk({p, "_ptr"}, mem_ptr, 0);
        chk({p, "_wdata"}, mem_wdata, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_gid"}, grant_id, 0);
        chk({p, "_to"}, timeout_err, 0);
    endtask

    // Asserts reset mid-cycle, checks outputs cleared at once, releases with the given requests.
    task automatic do_reset(input string p, input logic [N-1:0] elig, input logic md);
        @(posedge clk); #3;
        rst_l = 1'b0;
        #1 chk_zero(p);
        @(posedge clk); #1;
        idle_inputs();
        req_avail = elig; req_r_en = elig; mem_done = md;
        rst_l = 1'b1;
    endtask

    initial begin
        logic [N-1:0] oh;
        rst_l = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 chk_zero("rst");
        rst_l = 1'b1;

        // Single read from requester 2, memory answers on the third BUSY cycle.
        req_avail = 4'b0100; req_r_en = 4'b0100; req_ptr[2] = 32'h40;
        step();
        chk("rd_avail1", mem_avail, 1); chk("rd_r_en", mem_r_en, 1);
        chk("rd_ptr", mem_ptr, 32'h40); chk("rd_gid", grant_id, 2); chk("rd_busy", busy, 1);
        req_avail = '0;
        step(); chk("rd_avail2", mem_avail, 1);
        step(); chk("rd_avail3", mem_avail, 1);
        mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_done = 1'b0;
        chk("rd_done", req_done, 4'b0100); chk("rd_rdata", req_rdata, 32'hDEADBEEF);
        chk("rd_avail_off", mem_avail, 0);
        step(); chk("rd_done_clr", req_done, 0);
        idle_inputs();

        // Fairness: all eligible, one-cycle memory, grants 0,1,2,3,0.
        do_reset("rst_f", 4'hF, 1'b1);
        for (int r = 0; r < 5; r++) begin
            step();
            chk("fair_gid", grant_id, r % N); chk("fair_avail", mem_avail, 1);
            step();
            oh = '0; oh[r % N] = 1'b1;
            chk("fair_done", req_done, oh);
            if (r == 4) idle_inputs();
            step();
        end

        // Write wins over read; inputs changed during BUSY are ignored.
        req_avail = 4'b0010; req_r_en = 4'b0010; req_w_en = 4'b0010;
        req_ptr[1] = 32'h10; req_wdata[1] = 32'h5;
        step();
        chk("wr_gid", grant_id, 1);
        req_ptr[1] = 32'h99; req_wdata[1] = 32'h77; req_r_en = '0;
        for (int j = 0; j < 3; j++) begin
            chk("wr_w_en", mem_w_en, 1); chk("wr_r_en", mem_r_en, 0);
            chk("wr_ptr", mem_ptr, 32'h10); chk("wr_wdata", mem_wdata, 32'h5);
            if (j == 2) mem_done = 1'b1;
            step();
        end
        chk("wr_done", req_done, 4'b0010);
        idle_inputs();
        step();

        // Reset while requester 3 holds the port; requester 0 wins afterwards.
        req_avail = 4'b1000; req_r_en = 4'b1000;
        step();
        chk("rb_gid", grant_id, 3); chk("rb_busy", busy, 1);
        do_reset("rst_mid", 4'hF, 1'b0);
        step();
        chk("rb_first_gid", grant_id, 0); chk("rb_first_avail", mem_avail, 1);
        idle_inputs(); mem_done = 1'b1;
        step(); chk("rb_done", req_done, 4'b0001);
        step();

        // mem_done with nothing granted changes nothing.
        for (int j = 0; j < 3; j++) begin
            chk("sp_done", req_done, 0); chk("sp_busy", busy, 0); chk("sp_avail", mem_avail, 0);
            step();
        end
        mem_done = 1'b0;

`ifdef FPU_ARB_TIMEOUT_EN
        // Memory never answers: watchdog releases 9 cycles after mem_avail rises.
        req_avail = 4'b1100; req_r_en = 4'b1100;
        step(); chk("to_gid", grant_id, 2);
        repeat (8) step();
        chk("to_early", timeout_err, 0); chk("to_still_avail", mem_avail, 1);
        step();
        chk("to_err", timeout_err, 1); chk("to_done", req_done, 4'b0100); chk("to_rdata", req_rdata, 0);
        step(); step();
        chk("to_next_gid", grant_id, 3);
        idle_inputs(); mem_done = 1'b1;
        repeat (3) step();
        mem_done = 1'b0;
`endif

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            req_avail = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            req_r_en  = N'($urandom);
            req_w_en  = N'($urandom);
            for (int k = 0; k < N; k++) begin
                req_ptr[k]   = $urandom;
                req_wdata[k] = $urandom;
            end
            mem_done  = ($urandom_range(0, 99) < 35);
            mem_rdata = $urandom;
            if (i == 1500) do_reset("rst_rand", '0, 1'b0);
            else step();
        end

        idle_inputs();
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
